pla_vector_sequencer: RTL and testbench



---
 rtl/pla_vector_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pla_vector_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_vector_sequencer.sv
// Exhaustive vector driver and ones-count/MISR collector around a single-output PLA netlist.
// Define PLA_SEQ_LFSR_EN to source vectors from a maximal-length LFSR instead of a binary counter.
module pla_vector_sequencer #(
  parameter int unsigned         N_IN     = 19,
  parameter int unsigned         DUT_LAT  = 0,
  parameter int unsigned         SIG_W    = 16,
  parameter logic [SIG_W-1:0]    SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0]    SIG_SEED = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [N_IN-1:0]   x_out,
  output logic              x_valid,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     ones_count,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    x_q, x_d, vec_next, vec_first;
  logic               x_valid_q, x_valid_d, vec_last;
  logic [N_IN:0]      ones_q, ones_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               sample_en, start_fire;

`ifdef PLA_SEQ_LFSR_EN
  if (N_IN < 4 || N_IN > 24) begin : g_bad_width
    $error("pla_vector_sequencer: LFSR tap table covers N_IN 4..24 only");
  end

  function automatic logic [23:0] tap_mask(input int unsigned n);
    unique case (n)
      4:       return 24'h00000C;
      5:       return 24'h000014;
      6:       return 24'h000030;
      7:       return 24'h000060;
      8:       return 24'h0000B8;
      9:       return 24'h000110;
      10:      return 24'h000240;
      11:      return 24'h000500;
      12:      return 24'h000829;
      13:      return 24'h00100D;
      14:      return 24'h002015;
      15:      return 24'h006000;
      16:      return 24'h00D008;
      17:      return 24'h012000;
      18:      return 24'h020400;
      19:      return 24'h040023;
      20:      return 24'h090000;
      21:      return 24'h140000;
      22:      return 24'h300000;
      23:      return 24'h420000;
      24:      return 24'hE10000;
      default: return 24'h000000;
    endcase
  endfunction

  localparam logic [23:0] TAP_MASK = tap_mask(N_IN);

  logic [N_IN-1:0] lfsr_next;
  always_comb begin
    lfsr_next = {x_q[N_IN-2:0], ^(x_q & TAP_MASK[N_IN-1:0])};
    // Returning to the seed means all nonzero states were issued; emit zero as the last vector.
    vec_next  = (lfsr_next == N_IN'(1)) ? '0 : lfsr_next;
    vec_first = N_IN'(1);
    vec_last  = (x_q == '0);
  end
`else
  always_comb begin
    vec_next  = x_q + N_IN'(1);
    vec_first = '0;
    vec_last  = &x_q;
  end
`endif

  assign start_fire = start && (state_q == StIdle || state_q == StDone);

  if (DUT_LAT == 0) begin : g_no_lat
    assign sample_en = x_valid_q;
  end else begin : g_lat
    logic [DUT_LAT-1:0] valid_q, valid_d;
    always_comb begin
      valid_d    = valid_q;
      valid_d[0] = x_valid_q;
      for (int i = 1; i < int'(DUT_LAT); i++) valid_d[i] = valid_q[i-1];
    end
    always_ff @(posedge clk) begin
      if (rst || start_fire) valid_q <= '0;
      else if (!hold)        valid_q <= valid_d;
    end
    assign sample_en = valid_q[DUT_LAT-1];
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    ones_d    = ones_q;
    sig_d     = sig_q;
    drain_d   = drain_q;
    if ((state_q == StRun || state_q == StDrain) && sample_en && !hold) begin
      ones_d = ones_q + (N_IN+1)'(y_in);
      sig_d  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
             ^ {{(SIG_W-1){1'b0}}, y_in};
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          x_d       = vec_first;
          x_valid_d = 1'b1;
          ones_d    = '0;
          sig_d     = SIG_SEED;
          drain_d   = '0;
        end
      end
      StRun: begin
        if (!hold) begin
          if (vec_last) begin
            x_valid_d = 1'b0;
            state_d   = (DUT_LAT > 0) ? StDrain : StDone;
          end else begin
            x_d = vec_next;
          end
        end
      end
      StDrain: begin
        if (!hold) begin
          drain_d = drain_q + DW'(1);
          if (drain_q == DRAIN_LAST) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      ones_q    <= '0;
      sig_q     <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      ones_q    <= ones_d;
      sig_q     <= sig_d;
      drain_q   <= drain_d;
    end
  end

  assign x_out      = x_q;
  assign x_valid    = x_valid_q;
  assign busy       = (state_q == StRun) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign ones_count = ones_q;
  assign signature  = sig_q;

endmodule

// File: tb/tb_pla_vector_sequencer.sv
// Self-checking bench: three 4-input sequencers (latency 0, seed 0, latency 2) against a
// vector-order reference model with random truth tables, random holds and stray starts.
module tb_pla_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st = 1'b0;
  logic hd = 1'b0;
  logic yz = 1'b0;
  logic [15:0] tt = '0;
  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic [3:0] x0, x1, x2;
  logic xv0, xv1, xv2, b0, b1, b2, d0, d1, d2;
  logic [4:0] on0, on1, on2;
  logic [15:0] sg0, sg1, sg2;
  logic p1, p2;

  pla_vector_sequencer #(.N_IN(4), .DUT_LAT(0), .SIG_SEED(16'hFFFF)) dut0 (
    .clk(clk), .rst(rst), .start(sel == 0 && st), .hold(sel == 0 && hd),
    .x_out(x0), .x_valid(xv0), .y_in(tt[x0]), .busy(b0), .done(d0),
    .ones_count(on0), .signature(sg0));

  pla_vector_sequencer #(.N_IN(4), .DUT_LAT(0), .SIG_SEED(16'h0000)) dutz (
    .clk(clk), .rst(rst), .start(sel == 1 && st), .hold(sel == 1 && hd),
    .x_out(x1), .x_valid(xv1), .y_in(yz), .busy(b1), .done(d1),
    .ones_count(on1), .signature(sg1));

  pla_vector_sequencer #(.N_IN(4), .DUT_LAT(2), .SIG_SEED(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .start(sel == 2 && st), .hold(sel == 2 && hd),
    .x_out(x2), .x_valid(xv2), .y_in(p2), .busy(b2), .done(d2),
    .ones_count(on2), .signature(sg2));

  // Two-stage netlist stand-in that stalls together with the sequencer.
  always @(posedge clk) begin
    if (!(sel == 2 && hd)) begin
      p1 <= tt[x2];
      p2 <= p1;
    end
  end

  logic [3:0] ox;
  logic oxv, obusy, odone;
  logic [4:0] oones;
  logic [15:0] osig;
  always_comb begin
    ox = x0; oxv = xv0; obusy = b0; odone = d0; oones = on0; osig = sg0;
    if (sel == 1) begin
      ox = x1; oxv = xv1; obusy = b1; odone = d1; oones = on1; osig = sg1;
    end else if (sel == 2) begin
      ox = x2; oxv = xv2; obusy = b2; odone = d2; oones = on2; osig = sg2;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_checks++;
      if ({ox, oxv, obusy, odone, oones, osig} !== 29'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got x=%h v=%b busy=%b done=%b ones=%0d sig=%h, want all 0",
                 k, ox, oxv, obusy, odone, oones, osig);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full run on the selected instance; compares against the vector-order model.
  task automatic run_check(input int which, input int lat, input logic [15:0] seed,
                           input int hold_pct, input string name);
    logic [3:0] seq[$];
    logic [3:0] prev_x, fx;
    logic [4:0] fones;
    logic [15:0] fsig, m_sig;
    bit prev_hold;
    int n, held, done_n, drain_cycles, m_ones, y;
    sel = which;
    @(negedge clk);
    st = 1'b1;
    hd = 1'($urandom_range(0, 1));
    @(negedge clk);
    st = 1'b0;
    n = 1; held = 0; done_n = 0; drain_cycles = 0; prev_hold = 0; prev_x = '0;
    while (n < 200) begin
      if (odone) begin
        done_n = n;
        break;
      end
      n_checks++;
      if (obusy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b, want 1", name, n, obusy);
      end
      if (prev_hold) begin
        n_checks++;
        if (ox !== prev_x) begin
          n_fail++;
          $display("FAIL %s hold_freeze cycle %0d: got x=%h, want %h", name, n, ox, prev_x);
        end
      end
      hd = (hold_pct > 0) && ($urandom_range(0, 99) < hold_pct);
      if (hd) held++;
      if (oxv && !hd) seq.push_back(ox);
      if (!oxv && !hd) drain_cycles++;
      st = ($urandom_range(0, 9) == 0);
      prev_hold = hd;
      prev_x = ox;
      @(negedge clk);
      n++;
    end
    hd = 1'b0;
    st = 1'b0;

    n_checks++;
    if (done_n !== 17 + lat + held) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d cycles, want %0d", name, done_n, 17 + lat + held);
    end
    n_checks++;
    if (seq.size() != 16) begin
      n_fail++;
      $display("FAIL %s vector_count: got %0d, want 16", name, seq.size());
    end
    n_checks++;
    if (drain_cycles != lat) begin
      n_fail++;
      $display("FAIL %s drain_cycles: got %0d, want %0d", name, drain_cycles, lat);
    end
`ifdef PLA_SEQ_LFSR_EN
    for (int i = 0; i < seq.size(); i++)
      for (int j = i + 1; j < seq.size(); j++) begin
        n_checks++;
        if (seq[i] == seq[j]) begin
          n_fail++;
          $display("FAIL %s distinct: vector %0d and %0d both %h", name, i, j, seq[i]);
        end
      end
    if (seq.size() > 0) begin
      n_checks++;
      if (seq[seq.size()-1] !== 4'h0) begin
        n_fail++;
        $display("FAIL %s last_vector: got %h, want 0", name, seq[seq.size()-1]);
      end
    end
`else
    for (int i = 0; i < seq.size() && i < 16; i++) begin
      n_checks++;
      if (seq[i] !== 4'(i)) begin
        n_fail++;
        $display("FAIL %s vector_order %0d: got %h, want %h", name, i, seq[i], 4'(i));
      end
    end
`endif

    m_ones = 0;
    m_sig = seed;
    for (int v = 0; v < 16; v++) begin
      y = (which == 1) ? int'(yz) : int'(tt[v]);
      m_ones += y;
      m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(y);
    end
    n_checks++;
    if (oones !== 5'(m_ones)) begin
      n_fail++;
      $display("FAIL %s ones_count: got %0d, want %0d", name, oones, m_ones);
    end
`ifndef PLA_SEQ_LFSR_EN
    n_checks++;
    if (osig !== m_sig) begin
      n_fail++;
      $display("FAIL %s signature: got %h, want %h", name, osig, m_sig);
    end
`endif

    fx = ox; fones = oones; fsig = osig;
    repeat (3) begin
      hd = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({odone, obusy, oxv, ox, oones, osig} !== {1'b1, 1'b0, 1'b0, fx, fones, fsig}) begin
        n_fail++;
        $display("FAIL %s done_frozen: got done=%b busy=%b v=%b x=%h ones=%0d sig=%h",
                 name, odone, obusy, oxv, ox, oones, osig);
      end
    end
    hd = 1'b0;
  endtask

  task automatic test_lat0();
    tt = 16'h5555;
    run_check(0, 0, 16'hFFFF, 0, "lat0_x0");
    tt = 16'($urandom);
    run_check(0, 0, 16'hFFFF, 0, "lat0_rand");
    run_check(0, 0, 16'hFFFF, 30, "lat0_hold");
  endtask

  task automatic test_seed0();
    yz = 1'b0;
    run_check(1, 0, 16'h0000, 0, "seed0_y0");
    yz = 1'b1;
    run_check(1, 0, 16'h0000, 20, "seed0_y1");
  endtask

  task automatic test_rst_midrun();
    int k;
    sel = 0;
    tt = 16'($urandom);
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    k = 0;
    while (ox !== 4'd9 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (ox !== 4'd9) begin
      n_fail++;
      $display("FAIL rst_mid reach_9: got x=%h, want 9", ox);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ox, oxv, obusy, odone, oones, osig} !== 29'd0) begin
      n_fail++;
      $display("FAIL rst_mid clear: got x=%h v=%b busy=%b done=%b ones=%0d sig=%h, want all 0",
               ox, oxv, obusy, odone, oones, osig);
    end
    run_check(0, 0, 16'hFFFF, 0, "rst_rerun");
  endtask

  task automatic test_lat2();
    tt = 16'hFF00;
    run_check(2, 2, 16'hFFFF, 0, "lat2_x3");
    tt = 16'($urandom);
    run_check(2, 2, 16'hFFFF, 25, "lat2_hold");
  endtask

  initial begin
    test_reset();
    test_lat0();
    test_seed0();
    test_rst_midrun();
    test_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
